// File: rtl/robsmult_param.sv
`default_nettype none
// ============================================================================
//  Module      : robsmult_param
//  Description : Parametrised, restartable sequential Robertson's multiplier.
//                Multiplies two WIDTH-bit operands (signed or unsigned, chosen
//                per operation) retiring one multiplier bit per clock, with a
//                start/busy/done handshake. The 2*WIDTH-bit product is held
//                until the next completion.
//                Optional macro ROBSMULT_OVF_EN adds a registered 'ovf' output
//                flagging products that do not fit in WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module robsmult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef ROBSMULT_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int C_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH:0]       r_a;
    logic                 r_mode;
    logic [C_CW-1:0]      r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_yext;
    logic [WIDTH:0]       w_sum;
    logic                 w_fill;
    logic [WIDTH:0]       w_a_next;
    logic [WIDTH-1:0]     w_x_next;
    logic [2*WIDTH-1:0]   w_prod_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_count == C_CW'(WIDTH - 1));

    // Yext: sign- or zero-extension of the captured multiplicand
    assign w_yext = r_mode ? {r_y[WIDTH-1], r_y} : {1'b0, r_y};

    // Partial sum for this step; the final signed step subtracts (Robertson
    // correction for the negatively weighted multiplier MSB).
    always_comb begin
        w_sum = r_a;
        if (r_x[0]) begin
            if (w_last && r_mode) begin
                w_sum = r_a - w_yext;
            end else begin
                w_sum = r_a + w_yext;
            end
        end
    end

    // Signed mode replicates the sign bit. In unsigned mode the carry out of
    // the WIDTH-bit addition is S[WIDTH] itself and lands in A[WIDTH-1] after
    // the shift, so the vacated top bit must be zero to keep A exact.
    assign w_fill      = r_mode & w_sum[WIDTH];
    assign w_a_next    = {w_fill, w_sum[WIDTH:1]};
    assign w_x_next    = {w_sum[0], r_x[WIDTH-1:1]};
    assign w_prod_next = {w_a_next[WIDTH-1:0], w_x_next};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits for start, ITER runs WIDTH steps
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start)  w_state_next = S_ITER;
            S_ITER: if (w_last) w_state_next = S_IDLE;
            default:            w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iteration and result retirement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y       <= '0;
            r_x       <= '0;
            r_a       <= '0;
            r_mode    <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_y     <= multiplicand;
                r_x     <= multiplier;
                r_a     <= '0;
                r_mode  <= signed_mode;
                r_count <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == S_ITER) begin
                r_a     <= w_a_next;
                r_x     <= w_x_next;
                r_count <= r_count + C_CW'(1);
                if (w_last) begin
                    r_product <= w_prod_next;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
            end
        end
    end

`ifdef ROBSMULT_OVF_EN
    logic r_ovf;
    logic w_ovf_next;
    logic [WIDTH:0] w_hi_s;
    logic [WIDTH-1:0] w_hi_u;

    assign w_hi_s     = w_prod_next[2*WIDTH-1:WIDTH-1];
    assign w_hi_u     = w_prod_next[2*WIDTH-1:WIDTH];
    assign w_ovf_next = r_mode ? !((&w_hi_s) || !(|w_hi_s)) : (|w_hi_u);

    // Overflow flag, retired together with the product it describes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_ITER) && w_last) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_robsmult_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_robsmult_param
//  Description : Self-checking bench for robsmult_param at WIDTH=8 and
//                WIDTH=16 (directed vectors plus a reference-model sweep).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_robsmult_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start8, mode8, busy8, done8;
    logic [7:0]  x8, y8;
    logic [15:0] p8;
    logic        start16, mode16, busy16, done16;
    logic [15:0] x16, y16;
    logic [31:0] p16;
`ifdef ROBSMULT_OVF_EN
    logic        ovf8, ovf16;
`endif

    robsmult_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(mode8),
        .multiplier(x8), .multiplicand(y8),
        .busy(busy8), .done(done8), .product(p8)
`ifdef ROBSMULT_OVF_EN
        , .ovf(ovf8)
`endif
    );

    robsmult_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(mode16),
        .multiplier(x16), .multiplicand(y16),
        .busy(busy16), .done(done16), .product(p16)
`ifdef ROBSMULT_OVF_EN
        , .ovf(ovf16)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an operation and wait for done. cyc counts edges starting with
    // the accepting edge, so done after WIDTH iteration edges gives WIDTH+1.
    task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, output int cyc);
        start8 = 1'b1; mode8 = m; x8 = x; y8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; cyc = 1;
        while (!done8 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y, output int cyc);
        start16 = 1'b1; mode16 = m; x16 = x; y16 = y;
        @(posedge clk); #1;
        start16 = 1'b0; cyc = 1;
        while (!done16 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        start8 = 0; mode8 = 0; x8 = 0; y8 = 0;
        start16 = 0; mode16 = 0; x16 = 0; y16 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_prod", p8, 0);
        check("rst_prod16", p16, 0);
`ifdef ROBSMULT_OVF_EN
        check("rst_ovf", ovf8, 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // 7 * -3 signed
        op8(1'b1, 8'h07, 8'hFD, cyc);
        check("s_7x-3_lat", cyc, 9);
        check("s_7x-3", p8, 16'hFFEB);
        check("s_7x-3_busy", busy8, 0);
`ifdef ROBSMULT_OVF_EN
        check("s_7x-3_ovf", ovf8, 0);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done8, 0);

        // Most-negative squared, and unsigned all-ones squared
        op8(1'b1, 8'h80, 8'h80, cyc);
        check("s_80x80", p8, 16'h4000);
`ifdef ROBSMULT_OVF_EN
        check("s_80x80_ovf", ovf8, 1);
`endif
        @(posedge clk); #1;
        op8(1'b0, 8'hFF, 8'hFF, cyc);
        check("u_FFxFF", p8, 16'hFE01);
`ifdef ROBSMULT_OVF_EN
        check("u_FFxFF_ovf", ovf8, 1);
`endif
        @(posedge clk); #1;

        // Same bit patterns, different mode per operation
        op8(1'b1, 8'hFF, 8'h7F, cyc);
        check("s_-1x127", p8, 16'hFF81);
        @(posedge clk); #1;
        op8(1'b0, 8'hFF, 8'h7F, cyc);
        check("u_FFx7F", p8, 16'h7E81);
`ifdef ROBSMULT_OVF_EN
        check("u_FFx7F_ovf", ovf8, 1);
`endif
        @(posedge clk); #1;

        // 5*5 with a 9*9 start pulsed while busy
        start8 = 1'b1; mode8 = 1'b0; x8 = 8'd5; y8 = 8'd5;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy_after_accept", busy8, 1);
        ndone = 0; cyc = 1;
        repeat (2) begin @(posedge clk); #1; cyc++; end
        start8 = 1'b1; x8 = 8'd9; y8 = 8'd9;
        @(posedge clk); #1; cyc++;
        start8 = 1'b0; x8 = 8'd0; y8 = 8'd0;
        while (!done8 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        check("ign_lat", cyc, 9);
        check("ign_5x5", p8, 16'h0019);
        // Back-to-back start presented in the done cycle
        start8 = 1'b1; x8 = 8'd2; y8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_busy", busy8, 1);
        check("b2b_done_drop", done8, 0);
        check("b2b_prod_held", p8, 16'h0019);
        cyc = 1;
        while (!done8 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (done8 && p8 == 16'h0019) ndone++;
        end
        check("ign_single_done", ndone, 0);
        check("b2b_lat", cyc, 9);
        check("b2b_2x3", p8, 16'h0006);
        @(posedge clk); #1;

        // Reset in the middle of 100*100
        start8 = 1'b1; mode8 = 1'b0; x8 = 8'd100; y8 = 8'd100;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_prod", p8, 0);
        #3 reset = 1'b0;
        ndone = 0;
        repeat (15) begin @(posedge clk); #1; if (done8) ndone++; end
        check("arst_no_done", ndone, 0);
        op8(1'b0, 8'd12, 8'd12, cyc);
        check("u_12x12", p8, 16'h0090);
        @(posedge clk); #1;

        // WIDTH=16 corner
        op16(1'b1, 16'h8000, 16'h7FFF, cyc);
        check("w16_lat", cyc, 17);
        check("w16_s_min_max", p16, 32'hC0008000);
`ifdef ROBSMULT_OVF_EN
        check("w16_ovf", ovf16, 1);
`endif
        @(posedge clk); #1;

        // Signed/unsigned sweep against an independent multiply
        for (int k = 0; k < 1000; k++) begin
            logic        m;
            logic [15:0] a, b;
            logic [31:0] exp;
            int          sa, sb;
            longint      ua, ub;
            m = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if (m) begin
                sa = $signed(a); sb = $signed(b);
                exp = 32'(sa * sb);
            end else begin
                ua = longint'(a); ub = longint'(b);
                exp = 32'(ua * ub);
            end
            op16(m, a, b, cyc);
            check($sformatf("sweep%0d_%0h_%0h_m%0d", k, a, b, m), p16, exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
